irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt controller between the board push-buttons (i_io_btn, active-low) and the RISC core's external-interrupt input.
- Synchronises and edge-detects button presses into per-line pending bits, masks them, and selects one line by fixed priority.
- Presents a single request with a line ID to the core and sequences it through an ack/end-of-interrupt handshake (no nesting).
- Configured by the core through a small word-addressed register port on the LSU I/O bus.

Parameters:
- NUM_IRQ, 4: number of interrupt lines (one per button); ID width is $clog2(NUM_IRQ).
- DEBOUNCE_CYCLES, 16: stable-cycle count required when IRQ_DEBOUNCE_EN is defined; counter width is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_io_btn  in  NUM_IRQ  raw buttons, active-low (released = 1)
- i_wr_en  in  1  register write strobe
- i_addr  in  2  register word address
- i_wdata  in  32  register write data
- o_rdata  out  32  register read data (combinational on i_addr)
- o_irq  out  1  interrupt request to core
- o_irq_id  out  $clog2(NUM_IRQ)  ID of the requested/serviced line
- i_irq_ack  in  1  core accepts request (1-cycle pulse on trap entry)
- i_irq_eoi  in  1  core finished handler (1-cycle pulse on mret)

Behaviour:
- Clock is i_clk. Reset is i_rst_n, asynchronous assert, active-low, applied to all flops. There are no synchronous resets.
- Reset values:
  - o_irq = 0, o_irq_id = 0, state = IDLE.
  - ENABLE = 0, GIE = 0, PENDING = 0.
  - Synchroniser and previous-level flops = all 1s, so no spurious press is seen on reset release.
- Input path:
  - 2-flop synchroniser per line, giving a synced level.
  - Press event = previous level 1, current level 0.
  - Event sets PENDING[i] regardless of ENABLE.
  - Latency: button low at posedge N gives PENDING set at posedge N+3.
- Registers:
  - addr 0 ENABLE: RW. [NUM_IRQ-1:0] line enables, [31] GIE (global enable). Other bits read 0.
  - addr 1 PENDING: read returns pending bits; write-1-to-clear.
  - addr 2 STATUS: RO. [1:0] state encoding (IDLE=0, REQ=1, SERVICE=2), [5:4] o_irq_id, [8] o_irq.
  - addr 3 SWTRIG: write-only; write-1 sets PENDING bits. Reads 0.
  - Writes to RO addresses are ignored.
  - Same-cycle set and clear of one pending bit: set wins, for hardware event, SWTRIG, or ack. No event is ever lost.
- Selection:
  - eligible = PENDING & ENABLE[NUM_IRQ-1:0], gated by GIE.
  - Winner = lowest eligible index.
- FSM:
  - IDLE: if any line is eligible, latch the winner into o_irq_id and go to REQ. o_irq rises in the same cycle the state becomes REQ (registered).
  - REQ:
    - o_irq = 1; o_irq_id is held stable even if a higher-priority line becomes pending.
    - On i_irq_ack: clear PENDING[o_irq_id], drop o_irq, go to SERVICE.
    - If the latched line becomes ineligible before ack (ENABLE bit cleared, GIE cleared, or pending cleared by software): withdraw, o_irq = 0, go to IDLE. Ack in that same cycle wins over the withdrawal.
  - SERVICE:
    - o_irq = 0; o_irq_id is held.
    - New events accumulate in PENDING.
    - On i_irq_eoi: go to IDLE. Re-arbitration happens the next cycle, so minimum gap is eoi, then IDLE, then REQ.
  - Spurious handshakes: i_irq_ack outside REQ is ignored; i_irq_eoi outside SERVICE is ignored.
- Reset mid-operation returns everything to its reset values asynchronously. Pending state is discarded.

Optional Feature:
- Macro IRQ_DEBOUNCE_EN.
- Defined:
  - Each synced line has a counter.
  - The debounced level updates only after the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce back restarts the count.
  - Edge detection uses the debounced level, so latency = 3 + DEBOUNCE_CYCLES cycles.
  - The debounced level resets to 1.
- Undefined: counters are absent and edge detection uses the synced level directly. Latency is 3 cycles.

Test Plan:
- Reset, write addr0 = 0x8000_0001, then btn 4'hF to 4'hE for 1 cycle and back -> PENDING = 0x1 three cycles later; o_irq = 1 with id = 0 one cycle after that; STATUS reads 0x101.
- In REQ, pulse i_irq_ack -> o_irq = 0 next cycle, PENDING[0] = 0, STATUS[1:0] = 2. Pulse i_irq_eoi -> IDLE, o_irq stays 0.
- Enable all lines (0x8000_000F), SWTRIG write 0xC -> id = 2 requested first. Ack then eoi -> id = 3 requested two cycles after eoi.
- Line 1 in REQ, write addr0 = 0x8000_0000 -> o_irq drops next cycle, state IDLE, PENDING[1] still 1. Re-enable -> request reasserts with id = 1.
- During SERVICE, press btn 4'hC -> PENDING = 0x3 while o_irq stays 0. Assert i_rst_n = 0 mid-service -> o_irq = 0, PENDING = 0, STATUS = 0 immediately.
- With IRQ_DEBOUNCE_EN and DEBOUNCE_CYCLES = 16: btn0 low for 10 cycles -> no pending. Btn0 low for 20 cycles -> PENDING[0] set 19 cycles after the press.

Source files
------------

// File: rtl/irq_controller.sv
`timescale 1ns/1ps
// irq_controller
//
// Turns active-low push-button presses into interrupt requests for the RISC
// core. Each button is synchronised and edge-detected into a PENDING bit.
// Pending bits are masked by ENABLE and GIE, and the lowest eligible line wins.
// The winning line is presented on o_irq/o_irq_id and is walked through an
// ack / end-of-interrupt handshake. Nesting is not supported.
//
// Optional feature, selected by the macro IRQ_DEBOUNCE_EN:
//   defined   - the synced level must stay different from the debounced level
//               for DEBOUNCE_CYCLES consecutive cycles before the debounced
//               level follows it. Edges are detected on the debounced level.
//   undefined - edges are detected directly on the synced level.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_io_btn          raw buttons, active-low (released = 1)
//   i_wr_en, i_addr,  word-addressed register write port
//   i_wdata
//   o_rdata           register read data, combinational on i_addr
//                       0 ENABLE  [NUM_IRQ-1:0] line enables, [31] GIE
//                       1 PENDING read; write-1-to-clear
//                       2 STATUS  [1:0] state, [5:4] o_irq_id, [8] o_irq
//                       3 SWTRIG  write-1 sets PENDING; reads 0
//   o_irq, o_irq_id   request and line ID presented to the core
//   i_irq_ack         core accepted the request (pulse on trap entry)
//   i_irq_eoi         core finished its handler (pulse on mret)

module irq_controller #(
    parameter int NUM_IRQ         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int ID_W           = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_IRQ-1:0]  i_io_btn,
    input  logic                i_wr_en,
    input  logic [1:0]          i_addr,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata,
    output logic                o_irq,
    output logic [ID_W-1:0]     o_irq_id,
    input  logic                i_irq_ack,
    input  logic                i_irq_eoi
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SWTRIG  = 2'd3;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser, optional debounce, registered edge
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_evt;
    logic [NUM_IRQ-1:0] w_level;

    // Resetting to all 1s (released) keeps reset release from looking like a
    // press on every line.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_io_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef IRQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IRQ-1:0] r_deb;
    logic [CNT_W-1:0]   r_cnt [NUM_IRQ];

    // The count runs only while the synced level disagrees with the debounced
    // level; any agreement (a bounce back) restarts it from zero.
    // NOTE: the counter array is small flop storage, not a RAM, so every entry
    // is reset explicitly; a RAM-style array would normally be left unreset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deb <= '1;
            for (int i = 0; i < NUM_IRQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_deb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_sync2;
`endif

    // Press = falling edge of the (active-low) level. The event is registered,
    // giving a 3-cycle button-to-PENDING latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '1;
            r_evt  <= '0;
        end else begin
            r_prev <= w_level;
            r_evt  <= r_prev & ~w_level;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] r_enable;
    logic               r_gie;
    logic [NUM_IRQ-1:0] r_pending;
    state_t             r_state;
    logic               r_irq;
    logic [ID_W-1:0]    r_irq_id;

    logic w_wr_enable;
    logic w_wr_pending;
    logic w_wr_swtrig;
    logic w_ack_take;

    assign w_wr_enable  = i_wr_en && (i_addr == ADDR_ENABLE);
    assign w_wr_pending = i_wr_en && (i_addr == ADDR_PENDING);
    assign w_wr_swtrig  = i_wr_en && (i_addr == ADDR_SWTRIG);
    assign w_ack_take   = (r_state == ST_REQ) && i_irq_ack;

    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_id_onehot;

    assign w_id_onehot = NUM_IRQ'(1) << r_irq_id;
    assign w_set = r_evt | (w_wr_swtrig ? i_wdata[NUM_IRQ-1:0] : '0);
    assign w_clr = (w_wr_pending ? i_wdata[NUM_IRQ-1:0] : '0)
                 | (w_ack_take   ? w_id_onehot           : '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_enable  <= '0;
            r_gie     <= 1'b0;
            r_pending <= '0;
        end else begin
            if (w_wr_enable) begin
                r_enable <= i_wdata[NUM_IRQ-1:0];
                r_gie    <= i_wdata[31];
            end
            // Set is applied after clear so a same-cycle event is never lost.
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // ------------------------------------------------------------------
    // Selection: lowest eligible index wins
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] w_eligible;
    logic               w_any;
    logic [ID_W-1:0]    w_winner;

    assign w_eligible = r_gie ? (r_pending & r_enable) : '0;
    assign w_any      = |w_eligible;

    // NOTE: w_winner gets a default before the loop, so every path assigns it
    // and no latch is inferred.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_winner = ID_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // Request FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_irq_id <= w_winner;
                        r_irq    <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The latched ID is held even if a higher-priority line
                    // arrives; ack takes precedence over withdrawal.
                    if (i_irq_ack) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_SERVICE;
                    end else if (!w_eligible[r_irq_id]) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (i_irq_eoi) r_state <= ST_IDLE;
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_irq    = r_irq;
    assign o_irq_id = r_irq_id;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_enable_word;
    logic [31:0] w_status_word;

    always_comb begin
        w_enable_word                = '0;
        w_enable_word[NUM_IRQ-1:0]   = r_enable;
        w_enable_word[31]            = r_gie;
        w_status_word                = '0;
        w_status_word[1:0]           = r_state;
        w_status_word[4 +: ID_W]     = r_irq_id;
        w_status_word[8]             = r_irq;
    end

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            ADDR_ENABLE:  o_rdata = w_enable_word;
            ADDR_PENDING: o_rdata[NUM_IRQ-1:0] = r_pending;
            ADDR_STATUS:  o_rdata = w_status_word;
            ADDR_SWTRIG:  o_rdata = '0;
            default:      o_rdata = '0;
        endcase
    end

    // Write-data bits with no register behind them.
    logic w_unused_wdata;
    assign w_unused_wdata = ^i_wdata[30:NUM_IRQ];

endmodule

// File: tb/tb_irq_controller.sv
`timescale 1ns/1ps
module tb_irq_controller;

    localparam int NUM_IRQ = 4;
    localparam int DEB     = 16;
`ifdef IRQ_DEBOUNCE_EN
    localparam int LAT       = 3 + DEB;
    localparam int PRESS_LEN = DEB + 2;
`else
    localparam int LAT       = 3;
    localparam int PRESS_LEN = 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  i_io_btn = 4'hF;
    logic        i_wr_en = 1'b0;
    logic [1:0]  i_addr = 2'd0;
    logic [31:0] i_wdata = 32'h0;
    logic [31:0] o_rdata;
    logic        o_irq;
    logic [1:0]  o_irq_id;
    logic        i_irq_ack = 1'b0;
    logic        i_irq_eoi = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller #(.NUM_IRQ(NUM_IRQ), .DEBOUNCE_CYCLES(DEB)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_io_btn  (i_io_btn),
        .i_wr_en   (i_wr_en),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .o_rdata   (o_rdata),
        .o_irq     (o_irq),
        .o_irq_id  (o_irq_id),
        .i_irq_ack (i_irq_ack),
        .i_irq_eoi (i_irq_eoi)
    );

    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Reference model. The input path is a plain delay line of sampled
    // button values: a press sampled LAT edges ago (released one edge before
    // that) sets the pending bit now.
    // ------------------------------------------------------------------
    int         m_state;   // 0 idle, 1 request, 2 service
    logic       m_irq;
    logic [1:0] m_id;
    logic [3:0] m_pend, m_en;
    logic       m_gie;
    logic [3:0] m_hist [0:LAT];

    logic [3:0] m_elig, m_set, m_clr;
    logic       m_took_ack;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i]) lowest = 2'(i);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    m_read = {m_gie, 27'd0, m_en};
            2'd1:    m_read = {28'd0, m_pend};
            2'd2:    m_read = {23'd0, m_irq, 2'd0, m_id, 2'd0, 2'(m_state)};
            default: m_read = 32'd0;
        endcase
    endfunction

    assign m_elig     = m_gie ? (m_pend & m_en) : 4'h0;
    assign m_took_ack = (m_state == 1) && i_irq_ack;
    assign m_set      = (m_hist[LAT] & ~m_hist[LAT-1])
                      | ((i_wr_en && i_addr == 2'd3) ? i_wdata[3:0] : 4'h0);
    assign m_clr      = ((i_wr_en && i_addr == 2'd1) ? i_wdata[3:0] : 4'h0)
                      | (m_took_ack ? (4'd1 << m_id) : 4'h0);

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_state <= 0; m_irq <= 1'b0; m_id <= 2'd0;
            m_pend <= 4'h0; m_en <= 4'h0; m_gie <= 1'b0;
            for (int k = 0; k <= LAT; k++) m_hist[k] <= 4'hF;
        end else begin
            m_hist[0] <= i_io_btn;
            for (int k = 1; k <= LAT; k++) m_hist[k] <= m_hist[k-1];
            m_pend <= (m_pend & ~m_clr) | m_set;
            if (i_wr_en && i_addr == 2'd0) begin
                m_en  <= i_wdata[3:0];
                m_gie <= i_wdata[31];
            end
            if (m_state == 0 && m_elig != 4'h0) begin
                m_id <= lowest(m_elig); m_irq <= 1'b1; m_state <= 1;
            end else if (m_state == 1 && i_irq_ack) begin
                m_irq <= 1'b0; m_state <= 2;
            end else if (m_state == 1 && !m_elig[m_id]) begin
                m_irq <= 1'b0; m_state <= 0;
            end else if (m_state == 2 && i_irq_eoi) begin
                m_state <= 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change at the falling edge)
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        i_wr_en = 1'b1; i_addr = a; i_wdata = d;
        cyc();
        i_wr_en = 1'b0; i_wdata = 32'h0;
    endtask

    task automatic pulse_ack();
        i_irq_ack = 1'b1; cyc(); i_irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        i_irq_eoi = 1'b1; cyc(); i_irq_eoi = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        i_addr = a; #1; d = o_rdata;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        i_rst_n = 1'b0;
        repeat (3) cyc();
        i_rst_n = 1'b1;
        cyc();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", o_irq); end
        n_tests++; if (o_irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", o_irq_id); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00000000", a, d); end
        end
    endtask

    task automatic test_press_request();
        logic [31:0] d;
        do_write(2'd0, 32'h8000_0001);
        for (int c = 0; c <= LAT; c++) begin
            i_io_btn = (c < PRESS_LEN) ? 4'hE : 4'hF;
            cyc();
            if (c == LAT - 1) begin
                read_reg(2'd1, d);
                n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL press_early: got %h expected 00000000", d); end
            end
            if (c == LAT) begin
                read_reg(2'd1, d);
                n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL press_pending: got %h expected 00000001", d); end
                n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_early: got %0b expected 0", o_irq); end
            end
        end
        cyc();
        n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd0) begin n_fail++; $display("FAIL press_req: got irq=%0b id=%0d expected irq=1 id=0", o_irq, o_irq_id); end
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h101) begin n_fail++; $display("FAIL press_status: got %h expected 00000101", d); end
    endtask

    task automatic test_ack_eoi();
        logic [31:0] d;
        pulse_ack();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL ack_irq: got %0b expected 0", o_irq); end
        read_reg(2'd1, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL ack_pending: got %h expected 00000000", d); end
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL ack_status: got %h expected 00000002", d); end
        pulse_eoi();
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL eoi_status: got %h expected 00000000", d); end
        cyc();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL eoi_irq: got %0b expected 0", o_irq); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        do_write(2'd0, 32'h8000_000F);
        do_write(2'd3, 32'h0000_000C);
        read_reg(2'd3, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL swtrig_read: got %h expected 00000000", d); end
        cyc();
        n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd2) begin n_fail++; $display("FAIL prio_first: got irq=%0b id=%0d expected irq=1 id=2", o_irq, o_irq_id); end
        pulse_ack();
        read_reg(2'd1, d);
        n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL prio_pending: got %h expected 00000008", d); end
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h22) begin n_fail++; $display("FAIL prio_service: got %h expected 00000022", d); end
        pulse_eoi();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %0b expected 0", o_irq); end
        cyc();
        n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd3) begin n_fail++; $display("FAIL prio_second: got irq=%0b id=%0d expected irq=1 id=3", o_irq, o_irq_id); end
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        do_write(2'd3, 32'h2);
        cyc();
        n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd1) begin n_fail++; $display("FAIL wd_req: got irq=%0b id=%0d expected irq=1 id=1", o_irq, o_irq_id); end
        do_write(2'd0, 32'h8000_0000);
        cyc();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL wd_drop: got %0b expected 0", o_irq); end
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h10) begin n_fail++; $display("FAIL wd_status: got %h expected 00000010", d); end
        read_reg(2'd1, d);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL wd_pending: got %h expected 00000002", d); end
        do_write(2'd0, 32'h8000_000F);
        cyc();
        n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd1) begin n_fail++; $display("FAIL wd_rearm: got irq=%0b id=%0d expected irq=1 id=1", o_irq, o_irq_id); end
        pulse_ack();
    endtask

    task automatic test_service_reset();
        logic [31:0] d;
        for (int c = 0; c <= LAT; c++) begin
            i_io_btn = (c < PRESS_LEN) ? 4'hC : 4'hF;
            cyc();
        end
        read_reg(2'd1, d);
        n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL svc_pending: got %h expected 00000003", d); end
        cyc();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL svc_irq: got %0b expected 0", o_irq); end
        i_rst_n = 1'b0;
        #1;
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %0b expected 0", o_irq); end
        read_reg(2'd1, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %h expected 00000000", d); end
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h expected 00000000", d); end
        read_reg(2'd0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_enable: got %h expected 00000000", d); end
        cyc();
        i_rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        do_write(2'd0, 32'h8000_0001);
        do_write(2'd3, 32'h1);
        cyc();
        // Ack and a new software trigger of the same line in one cycle.
        i_irq_ack = 1'b1; i_wr_en = 1'b1; i_addr = 2'd3; i_wdata = 32'h1;
        cyc();
        i_irq_ack = 1'b0; i_wr_en = 1'b0; i_wdata = 32'h0;
        read_reg(2'd1, d);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL col_setwins: got %h expected 00000001", d); end
        pulse_ack();
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL col_spur_ack: got %h expected 00000002", d); end
        pulse_eoi();
        cyc();
        pulse_eoi();
        n_tests++; if (o_irq !== 1'b1 || o_irq_id !== 2'd0) begin n_fail++; $display("FAIL col_spur_eoi: got irq=%0b id=%0d expected irq=1 id=0", o_irq, o_irq_id); end
        // Software clear and ack together: ack wins.
        i_irq_ack = 1'b1; i_wr_en = 1'b1; i_addr = 2'd1; i_wdata = 32'h1;
        cyc();
        i_irq_ack = 1'b0; i_wr_en = 1'b0; i_wdata = 32'h0;
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL col_ackwins: got %h expected 00000002", d); end
        pulse_eoi();
        do_write(2'd2, 32'hFFFF_FFFF);
        read_reg(2'd2, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL col_ro_write: got %h expected 00000000", d); end
        read_reg(2'd0, d);
        n_tests++; if (d !== 32'h8000_0001) begin n_fail++; $display("FAIL col_enable: got %h expected 80000001", d); end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        i_rst_n = 1'b0; cyc(); i_rst_n = 1'b1; cyc();
        for (int n = 0; n < 3000; n++) begin
`ifdef IRQ_DEBOUNCE_EN
            i_io_btn = 4'hF;
`else
            i_io_btn = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
`endif
            i_wr_en   = ($urandom_range(0, 7) == 0);
            i_addr    = 2'($urandom);
            i_wdata   = $urandom;
            if (i_addr == 2'd0) i_wdata[31] = ($urandom_range(0, 3) != 0);
            i_irq_ack = ($urandom_range(0, 2) == 0);
            i_irq_eoi = ($urandom_range(0, 3) == 0);
            cyc();
            exp_d = m_read(i_addr);
            n_tests++; if (o_irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq@%0d: got %0b expected %0b", n, o_irq, m_irq); end
            n_tests++; if (o_irq_id !== m_id) begin n_fail++; $display("FAIL rnd_id@%0d: got %0d expected %0d", n, o_irq_id, m_id); end
            n_tests++; if (o_rdata !== exp_d) begin n_fail++; $display("FAIL rnd_rdata@%0d addr %0d: got %h expected %h", n, i_addr, o_rdata, exp_d); end
        end
        i_io_btn = 4'hF; i_wr_en = 1'b0; i_irq_ack = 1'b0; i_irq_eoi = 1'b0;
    endtask

`ifdef IRQ_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] d;
        i_rst_n = 1'b0; cyc(); i_rst_n = 1'b1; cyc();
        i_io_btn = 4'hE; repeat (10) cyc();
        i_io_btn = 4'hF; repeat (40) cyc();
        read_reg(2'd1, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL deb_short: got %h expected 00000000", d); end
        for (int c = 0; c < 25; c++) begin
            i_io_btn = (c < 20) ? 4'hE : 4'hF;
            cyc();
            if (c == 18) begin
                read_reg(2'd1, d);
                n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL deb_early: got %h expected 00000000", d); end
            end
            if (c == 19) begin
                read_reg(2'd1, d);
                n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL deb_long: got %h expected 00000001", d); end
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_press_request();
        test_ack_eoi();
        test_priority();
        test_withdraw();
        test_service_reset();
        test_collisions();
        test_random();
`ifdef IRQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
